activation_pipe: RTL and testbench

Streaming, pipelined activation unit that supersedes the combinational per-vector ReLU in the layer datapath. It applies a runtime-selectable activation (bypass, ReLU, leaky ReLU, clipped ReLU) to N signed lanes per beat. It moves data over valid/ready handshakes with full backpressure and one beat per cycle of throughput. A saturating counter reports how many elements the activation modified.

---
 rtl/activation_pipe_if.sv | 25 ++
 rtl/activation_pipe.sv | 134 +++++++++++++
 tb/tb_activation_pipe.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/activation_pipe_if.sv
// Beat-stream handshake bundle for activation_pipe: upstream input beats and
// downstream output beats, both valid/ready.
interface activation_pipe_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N-1:0][WIDTH-1:0] in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [N-1:0][WIDTH-1:0] out_data;
  logic                    out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/activation_pipe.sv
// Two-stage streaming activation (bypass / ReLU / leaky / clipped) over N lanes,
// full backpressure, plus a saturating count of lanes the activation changed.
module activation_lane #(
  parameter int WIDTH      = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] clip_i,
  output logic [WIDTH-1:0] y_o,
  output logic             mod_o
);
  logic neg;
  assign neg = x_i[WIDTH-1];

  always_comb begin
    y_o = x_i;
    unique case (mode_i)
      2'd1: if (neg) y_o = '0;
      2'd2: if (neg) y_o = $signed(x_i) >>> LEAK_SHIFT;
      2'd3: begin
        if (neg)                                 y_o = '0;
        else if ($signed(x_i) > $signed(clip_i)) y_o = clip_i;
      end
      default: ;
    endcase
  end

  assign mod_o = (y_o != x_i);
endmodule

module activation_pipe #(
  parameter int WIDTH      = 16,
  parameter int N          = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_mode,
  input  logic [WIDTH-1:0]   cfg_clip,
  input  logic               clr_stats,
  output logic [CNT_W-1:0]   mod_count,
  activation_pipe_if.slave   bus
);
  localparam int NMW = $clog2(N + 1);
  localparam int CW1 = CNT_W + 1;
  localparam logic [WIDTH-1:0] CLIP_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  // Stage-1 payload carries its own config snapshot so later writes can't touch it.
  typedef struct packed {
    logic [N-1:0][WIDTH-1:0] data;
    logic                    last;
    logic [1:0]              mode;
    logic [WIDTH-1:0]        clip;
  } s1_t;

  logic [2:1]              vld_pipe_q;
  s1_t                     s1_q;
  logic [1:0]              mode_q;
  logic [WIDTH-1:0]        clip_q;
  logic [N-1:0][WIDTH-1:0] out_data_q;
  logic                    out_last_q;
  logic [NMW-1:0]          nmod_q;
  logic [CNT_W-1:0]        cnt_q;

  logic [N-1:0][WIDTH-1:0] y_d;
  logic [N-1:0]            mod_d;
  logic [NMW-1:0]          nmod_d;
  logic [CNT_W:0]          sum_d;
  logic                    s1_load, s2_load, acc, out_hs;

  assign s2_load      = !vld_pipe_q[2] || bus.out_ready;
  assign s1_load      = !vld_pipe_q[1] || s2_load;
  assign bus.in_ready = rst_n && s1_load;
  assign acc          = bus.in_valid && bus.in_ready;
  assign out_hs       = vld_pipe_q[2] && bus.out_ready;

  for (genvar g = 0; g < N; g++) begin : g_lane
    activation_lane #(.WIDTH(WIDTH), .LEAK_SHIFT(LEAK_SHIFT)) u_lane (
      .x_i    (s1_q.data[g]),
      .mode_i (s1_q.mode),
      .clip_i (s1_q.clip),
      .y_o    (y_d[g]),
      .mod_o  (mod_d[g])
    );
  end

  always_comb begin
    nmod_d = '0;
    for (int i = 0; i < N; i++) nmod_d = nmod_d + NMW'(mod_d[i]);
  end

  // One spare bit catches the carry that signals saturation.
  assign sum_d = {1'b0, cnt_q} + CW1'(nmod_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      mode_q     <= 2'd1;
      clip_q     <= CLIP_MAX;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      nmod_q     <= '0;
      cnt_q      <= '0;
    end else begin
      if (cfg_we) begin
        mode_q <= cfg_mode;
        clip_q <= cfg_clip[WIDTH-1] ? '0 : cfg_clip;
      end
      if (s1_load) begin
        vld_pipe_q[1] <= acc;
        if (acc) s1_q <= '{data: bus.in_data, last: bus.in_last, mode: mode_q, clip: clip_q};
      end
      if (s2_load) begin
        vld_pipe_q[2] <= vld_pipe_q[1];
        if (vld_pipe_q[1]) begin
          out_data_q <= y_d;
          out_last_q <= s1_q.last;
          nmod_q     <= nmod_d;
        end
      end
      if (clr_stats)   cnt_q <= '0;
      else if (out_hs) cnt_q <= sum_d[CNT_W] ? '1 : sum_d[CNT_W-1:0];
    end
  end

  assign bus.out_valid = vld_pipe_q[2];
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign mod_count     = cnt_q;
endmodule

// File: tb/tb_activation_pipe.sv
// Directed + random bench for activation_pipe against a queue-based beat model;
// a second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_activation_pipe;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int LS = 3;
  localparam longint MAX_A = 65535;
  localparam longint MAX_B = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic [W-1:0] cfg_clip = '0;
  logic clr_stats = 1'b0;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  activation_pipe_if #(.WIDTH(W), .N(N)) bus_a ();
  activation_pipe_if #(.WIDTH(W), .N(N)) bus_b ();

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_data   = bus_a.in_data;
  assign bus_b.in_last   = bus_a.in_last;
  assign bus_b.out_ready = bus_a.out_ready;

  activation_pipe #(.WIDTH(W), .N(N), .LEAK_SHIFT(LS), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_clip(cfg_clip),
    .clr_stats(clr_stats), .mod_count(cnt_a), .bus(bus_a));

  activation_pipe #(.WIDTH(W), .N(N), .LEAK_SHIFT(LS), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_clip(cfg_clip),
    .clr_stats(clr_stats), .mod_count(cnt_b), .bus(bus_b));

  typedef struct {
    logic [N-1:0][W-1:0] y;
    logic                last;
    int                  nmod;
    longint              edge_no;
  } beat_t;

  beat_t  q[$];
  int     errors = 0;
  int     checks = 0;
  int     m_mode = 1;
  int     m_clip = 32767;
  longint m_cnt_a = 0;
  longint m_cnt_b = 0;
  longint cyc = 0;
  bit     acc_f;

  function automatic logic [N-1:0][W-1:0] pk(int a, int b, int c, int d);
    logic [N-1:0][W-1:0] v;
    v[0] = 16'(a); v[1] = 16'(b); v[2] = 16'(c); v[3] = 16'(d);
    return v;
  endfunction

  // Leaky result is floor(x / 2^LS), written as a negated ceiling division.
  function automatic int act(int x, int mode, int clip);
    if (mode == 0) return x;
    if (x < 0) return (mode == 2) ? -((-x + (1 << LS) - 1) / (1 << LS)) : 0;
    if (mode == 3 && x > clip) return clip;
    return x;
  endfunction

  function automatic logic [W-1:0] rnd_lane();
    case ($urandom % 6)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at negedge, update the model with this edge's handshakes.
  task automatic tick();
    bit exp_vld, exp_rdy;
    beat_t b;
    @(negedge clk);
    exp_rdy = (q.size() < 2) || bus_a.out_ready;
    exp_vld = (q.size() > 0) && (cyc > q[0].edge_no);
    chk("in_ready", bus_a.in_ready, exp_rdy);
    chk("out_valid", bus_a.out_valid, exp_vld);
    if (exp_vld) begin
      chk("out_data", bus_a.out_data, q[0].y);
      chk("out_last", bus_a.out_last, q[0].last);
    end
    chk("mod_count", cnt_a, m_cnt_a);
    chk("mod_count_sat", cnt_b, m_cnt_b);
    if (clr_stats) begin
      m_cnt_a = 0; m_cnt_b = 0;
      if (exp_vld && bus_a.out_ready) void'(q.pop_front());
    end else if (exp_vld && bus_a.out_ready) begin
      b = q.pop_front();
      m_cnt_a = (m_cnt_a + b.nmod > MAX_A) ? MAX_A : m_cnt_a + b.nmod;
      m_cnt_b = (m_cnt_b + b.nmod > MAX_B) ? MAX_B : m_cnt_b + b.nmod;
    end
    acc_f = bus_a.in_valid && exp_rdy;
    if (acc_f) begin
      b.nmod = 0;
      for (int i = 0; i < N; i++) begin
        b.y[i] = 16'(act(int'($signed(bus_a.in_data[i])), m_mode, m_clip));
        if (b.y[i] != bus_a.in_data[i]) b.nmod++;
      end
      b.last = bus_a.in_last;
      b.edge_no = cyc + 1;
      q.push_back(b);
    end
    if (cfg_we) begin
      m_mode = int'(cfg_mode);
      m_clip = ($signed(cfg_clip) < 0) ? 0 : int'($signed(cfg_clip));
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(logic [N-1:0][W-1:0] d, logic l);
    int k = 0;
    bus_a.in_valid = 1'b1; bus_a.in_data = d; bus_a.in_last = l;
    do begin tick(); k++; end while (!acc_f && k < 20);
    chk("send_timeout", acc_f, 1'b1);
    bus_a.in_valid = 1'b0;
  endtask

  task automatic setcfg(int mode, int clip);
    cfg_we = 1'b1; cfg_mode = 2'(mode); cfg_clip = 16'(clip);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_out(string tag, logic [N-1:0][W-1:0] exp);
    int k = 0;
    while (!bus_a.out_valid && k < 8) begin tick(); k++; end
    chk({tag, "_timeout"}, bus_a.out_valid, 1'b1);
    chk(tag, bus_a.out_data, exp);
  endtask

  initial begin
    int sent, t;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus_a.in_ready, 1'b0);
    chk("rst_out_valid", bus_a.out_valid, 1'b0);
    chk("rst_out_data", bus_a.out_data, 64'h0);
    chk("rst_out_last", bus_a.out_last, 1'b0);
    chk("rst_mod_count", cnt_a, 16'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Default ReLU straight out of reset.
    send(pk(-5, 0, 7, -32768), 1'b1);
    wait_out("relu_default", pk(0, 0, 7, 0));
    tick();
    chk("relu_count", cnt_a, 16'd2);

    setcfg(2, 0);
    send(pk(-8, -1, -9, 100), 1'b0);
    wait_out("leaky", pk(-1, -1, -2, 100));
    tick();
    chk("leaky_count", cnt_a, 16'd4);

    setcfg(3, 6);
    send(pk(-3, 3, 6, 200), 1'b0);
    wait_out("clip6", pk(0, 3, 6, 6));
    setcfg(3, -4);
    send(pk(5, 1, 0, -2), 1'b1);
    wait_out("clip_neg", pk(0, 0, 0, 0));
    tick();
    chk("clip_count", cnt_a, 16'd9);

    // Config write coinciding with acceptance applies only to the next beat.
    setcfg(1, 32767);
    bus_a.in_valid = 1'b1; bus_a.in_data = pk(-7, 3, -1, 2); bus_a.in_last = 1'b0;
    cfg_we = 1'b1; cfg_mode = 2'd0;
    tick();
    cfg_we = 1'b0; bus_a.in_data = pk(-4, 5, -6, 0);
    tick();
    bus_a.in_valid = 1'b0;
    chk("hazard_old_mode", bus_a.out_data, pk(0, 3, 0, 2));
    tick();
    chk("hazard_new_mode", bus_a.out_data, pk(-4, 5, -6, 0));
    repeat (2) tick();

    // Saturation of the 4-bit instance, then clear coincident with a handshake.
    setcfg(1, 32767);
    for (int i = 0; i < 5; i++) send(pk(-1, -1, -1, -1), 1'b0);
    repeat (3) tick();
    chk("sat_hold", cnt_b, 4'd15);
    send(pk(-1, -1, -1, -1), 1'b0);
    wait_out("clr_beat", pk(0, 0, 0, 0));
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_a", cnt_a, 16'd0);
    chk("clr_b", cnt_b, 4'd0);

    // Backpressure: out_ready pattern 1,0,0 over 10 beats.
    sent = 0; t = 0;
    while ((sent < 10 || q.size() > 0) && t < 200) begin
      bus_a.out_ready = (t % 3 == 0);
      bus_a.in_valid = (sent < 10);
      bus_a.in_data = pk(-sent, sent * 100, -(sent * 1000) - 1, sent);
      bus_a.in_last = (sent == 9);
      tick();
      if (acc_f) sent++;
      t++;
    end
    chk("bp_complete", (t < 200), 1'b1);
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    tick();

    // Async reset with two beats stalled in flight.
    bus_a.out_ready = 1'b0;
    send(pk(-1, 2, -3, 4), 1'b0);
    send(pk(5, -6, 7, -8), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus_a.out_valid, 1'b0);
    chk("arst_in_ready", bus_a.in_ready, 1'b0);
    chk("arst_count", cnt_a, 16'd0);
    q.delete(); m_mode = 1; m_clip = 32767; m_cnt_a = 0; m_cnt_b = 0;
    @(negedge clk); rst_n = 1'b1; bus_a.out_ready = 1'b1;
    @(posedge clk); cyc++; #1;
    repeat (4) tick();

    // Random traffic with occasional config writes and clears.
    for (int i = 0; i < 600; i++) begin
      bus_a.in_valid = ($urandom % 4) != 0;
      bus_a.out_ready = ($urandom % 3) != 0;
      for (int l = 0; l < N; l++) bus_a.in_data[l] = rnd_lane();
      bus_a.in_last = $urandom % 2;
      cfg_we = ($urandom % 16) == 0;
      cfg_mode = 2'($urandom);
      cfg_clip = ($urandom % 2) ? 16'($urandom % 300) : 16'($urandom);
      clr_stats = ($urandom % 50) == 0;
      tick();
    end
    cfg_we = 1'b0; clr_stats = 1'b0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
